// File: rtl/wave_param_loader.sv
// Parameter loader for the 64-channel oscillator summing block: bursts fill shadow
// banks, and a commit copies all three shadow banks to the active buses in one edge.
module wave_param_loader #(
    parameter int NCH = 64,
    parameter int W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [1:0]         cmd_sel,
    input  logic [5:0]         cmd_chan,
    input  logic [5:0]         cmd_len,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic [W-1:0]       data,
    output logic [NCH*W-1:0]   amps,
    output logic [NCH*W-1:0]   offsets,
    output logic [NCH*W-1:0]   phasewords,
    output logic               commit_done,
    output logic               err,
    output logic               state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // cmd_ready is high only in IDLE and data_ready only in BURST.
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [1:0] OP_BURST  = 2'b00;
    localparam logic [1:0] OP_COMMIT = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [5:0]         ptr_q, ptr_d;
    logic [5:0]         rem_q, rem_d;
    logic               commit_done_q, commit_done_d;
    logic               err_q, err_d;
    logic [NCH*W-1:0]   amp_sh_q, amp_sh_d, off_sh_q, off_sh_d, ph_sh_q, ph_sh_d;
    logic [NCH*W-1:0]   amps_q, amps_d, offsets_q, offsets_d, ph_q, ph_d;
    logic [9:0]         lane_lo;

    // Lane base bit offset: channel * 16, with the channel count fixed at 64.
    assign lane_lo = {ptr_q, 4'b0000};

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        ptr_d         = ptr_q;
        rem_d         = rem_q;
        commit_done_d = 1'b0;
        err_d         = err_q;
        amp_sh_d      = amp_sh_q;
        off_sh_d      = off_sh_q;
        ph_sh_d       = ph_sh_q;
        amps_d        = amps_q;
        offsets_d     = offsets_q;
        ph_d          = ph_q;
        cmd_ready     = (state_q == IDLE);
        data_ready    = (state_q == BURST);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_BURST: begin
                            sel_d   = cmd_sel;
                            ptr_d   = cmd_chan;
                            rem_d   = cmd_len;
                            state_d = BURST;
                            if (cmd_sel == 2'b11) err_d = 1'b1;
                        end
                        OP_COMMIT: begin
                            amps_d        = amp_sh_q;
                            offsets_d     = off_sh_q;
                            ph_d          = ph_sh_q;
                            commit_done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            amp_sh_d = '0;
                            off_sh_d = '0;
                            ph_sh_d  = '0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            BURST: begin
                if (data_valid) begin
                    // Bank 11 runs the full handshake but its writes go nowhere.
                    case (sel_q)
                        2'b00:   amp_sh_d[lane_lo +: W] = data;
                        2'b01:   off_sh_d[lane_lo +: W] = data;
                        2'b10:   ph_sh_d[lane_lo +: W]  = data;
                        default: ;
                    endcase
                    ptr_d = ptr_q + 6'd1;
                    if (rem_q == 6'd0) state_d = IDLE;
                    else               rem_d   = rem_q - 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= 2'b00;
            ptr_q         <= 6'd0;
            rem_q         <= 6'd0;
            commit_done_q <= 1'b0;
            err_q         <= 1'b0;
            amp_sh_q      <= '0;
            off_sh_q      <= '0;
            ph_sh_q       <= '0;
            amps_q        <= '0;
            offsets_q     <= '0;
            ph_q          <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            ptr_q         <= ptr_d;
            rem_q         <= rem_d;
            commit_done_q <= commit_done_d;
            err_q         <= err_d;
            amp_sh_q      <= amp_sh_d;
            off_sh_q      <= off_sh_d;
            ph_sh_q       <= ph_sh_d;
            amps_q        <= amps_d;
            offsets_q     <= offsets_d;
            ph_q          <= ph_d;
        end
    end

    assign amps        = amps_q;
    assign offsets     = offsets_q;
    assign phasewords  = ph_q;
    assign commit_done = commit_done_q;
    assign err         = err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_wave_param_loader.sv
// Bench for wave_param_loader: directed bursts/commits; a monitor checks every
// commit_done pulse against the expected bus set queued when the commit was issued.
module tb_wave_param_loader;

    localparam int BW = 1024;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [1:0]    cmd_sel = 2'b00;
    logic [5:0]    cmd_chan = 6'd0;
    logic [5:0]    cmd_len = 6'd0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [15:0]   data = 16'h0;
    logic [BW-1:0] amps, offsets, phasewords;
    logic          commit_done, err, state_dbg;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0]   m_sh [3];
    logic [3*BW-1:0] exp_q [$];

    wave_param_loader dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_chan(cmd_chan), .cmd_len(cmd_len),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .amps(amps), .offsets(offsets), .phasewords(phasewords),
        .commit_done(commit_done), .err(err), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checkers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        int lane;
        checks++;
        if (act !== exp) begin
            errors++;
            lane = 0;
            for (int i = 63; i >= 0; i--)
                if (act[i*16 +: 16] !== exp[i*16 +: 16]) lane = i;
            $display("FAIL %s: lane %0d actual %h required %h", name, lane,
                     act[lane*16 +: 16], exp[lane*16 +: 16]);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset && commit_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_pulse: actual unexpected pulse required none");
            end else begin
                logic [3*BW-1:0] e;
                e = exp_q.pop_front();
                chk_bus("commit_amps", amps, e[BW-1:0]);
                chk_bus("commit_offsets", offsets, e[2*BW-1:BW]);
                chk_bus("commit_phasewords", phasewords, e[3*BW-1:2*BW]);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] sel,
                            input logic [5:0] chan, input logic [5:0] len);
        int t;
        t = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_chan = chan; cmd_len = len;
        while (!cmd_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input int gap);
        int t;
        t = 0;
        data_valid = 1'b1; data = d;
        while (!data_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!data_ready) chk("data_ready_timeout", 32'(data_ready), 32'd1);
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic burst(input int sel, input int chan, input int len,
                         input logic [15:0] d0, input logic [15:0] dinc, input int gap);
        logic [15:0] d;
        int lane;
        send_cmd(2'b00, 2'(sel), 6'(chan), 6'(len));
        for (int i = 0; i <= len; i++) begin
            d = d0 + 16'(i) * dinc;
            lane = (chan + i) % 64;
            if (sel < 3) m_sh[sel][lane*16 +: 16] = d;
            send_word(d, (i == len) ? 0 : gap);
            if (i != len) begin
                chk("mid_burst_cmd_ready", 32'(cmd_ready), 32'd0);
                chk("mid_burst_data_ready", 32'(data_ready), 32'd1);
            end
        end
        chk("post_burst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_burst_data_ready", 32'(data_ready), 32'd0);
    endtask

    task automatic commit();
        exp_q.push_back({m_sh[2], m_sh[1], m_sh[0]});
        send_cmd(2'b01, 2'b00, 6'd0, 6'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [BW-1:0] exp_bus;
        logic [BW-1:0] prev_a, prev_o, prev_p;
        for (int b = 0; b < 3; b++) m_sh[b] = '0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_bus("reset_amps", amps, '0);
        chk_bus("reset_offsets", offsets, '0);
        chk_bus("reset_phasewords", phasewords, '0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_data_ready", 32'(data_ready), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_commit_done", 32'(commit_done), 32'd0);

        // Full amplitude burst; nothing visible until commit.
        burst(0, 0, 63, 16'h1000, 16'h0000, 0);
        chk_bus("amps_before_commit", amps, '0);
        commit();
        chk_bus("amps_after_commit", amps, {64{16'h1000}});
        @(posedge clk); #1;
        chk("commit_done_one_cycle", 32'(commit_done), 32'd0);

        // Phaseword burst wrapping from lane 62 to lane 1.
        burst(2, 62, 3, 16'h0001, 16'h0001, 0);
        commit();
        exp_bus = '0;
        exp_bus[62*16 +: 16] = 16'h0001;
        exp_bus[63*16 +: 16] = 16'h0002;
        exp_bus[0 +: 16]     = 16'h0003;
        exp_bus[16 +: 16]    = 16'h0004;
        chk_bus("phase_wrap", phasewords, exp_bus);

        // Stalling burst: data_valid low every other cycle, 5 words.
        burst(1, 10, 4, 16'h00A0, 16'h0001, 1);
        commit();
        exp_bus = '0;
        for (int i = 0; i < 5; i++) exp_bus[(10+i)*16 +: 16] = 16'h00A0 + 16'(i);
        chk_bus("stall_offsets", offsets, exp_bus);

        // Back-to-back commits give back-to-back pulses.
        commit();
        chk("b2b_pulse1", 32'(commit_done), 32'd1);
        commit();
        chk("b2b_pulse2", 32'(commit_done), 32'd1);

        // Invalid bank burst and reserved op: err sticky, nothing written.
        chk("err_before", 32'(err), 32'd0);
        prev_a = amps; prev_o = offsets; prev_p = phasewords;
        send_cmd(2'b00, 2'b11, 6'd5, 6'd1);
        chk("err_at_bad_sel", 32'(err), 32'd1);
        send_word(16'hDEAD, 0);
        send_word(16'hBEEF, 0);
        chk("bad_sel_cmd_ready", 32'(cmd_ready), 32'd1);
        send_cmd(2'b11, 2'b00, 6'd0, 6'd0);
        chk("err_after_reserved", 32'(err), 32'd1);
        chk("reserved_cmd_ready", 32'(cmd_ready), 32'd1);
        commit();
        chk_bus("bad_sel_amps", amps, prev_a);
        chk_bus("bad_sel_offsets", offsets, prev_o);
        chk_bus("bad_sel_phase", phasewords, prev_p);

        // Clear leaves active buses alone until the next commit.
        burst(1, 0, 63, 16'h00FF, 16'h0000, 0);
        commit();
        chk_bus("offsets_loaded", offsets, {64{16'h00FF}});
        send_cmd(2'b10, 2'b00, 6'd0, 6'd0);
        for (int b = 0; b < 3; b++) m_sh[b] = '0;
        chk_bus("offsets_after_clear", offsets, {64{16'h00FF}});
        chk_bus("amps_after_clear", amps, {64{16'h1000}});
        commit();
        chk_bus("offsets_cleared_commit", offsets, '0);
        chk("err_still_set", 32'(err), 32'd1);

        // Reload some amplitudes, then reset in the middle of a burst.
        burst(0, 0, 63, 16'h0123, 16'h0000, 0);
        commit();
        send_cmd(2'b00, 2'b01, 6'd0, 6'd7);
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        chk("mid_burst_state", 32'(state_dbg), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_bus("async_reset_amps", amps, '0);
        chk_bus("async_reset_offsets", offsets, '0);
        chk_bus("async_reset_phase", phasewords, '0);
        chk("async_reset_state", 32'(state_dbg), 32'd0);
        chk("async_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("async_reset_data_ready", 32'(data_ready), 32'd0);
        chk("async_reset_err", 32'(err), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int b = 0; b < 3; b++) m_sh[b] = '0;
        commit();
        chk_bus("post_reset_commit_amps", amps, '0);

        repeat (3) @(posedge clk);
        #1;
        chk("pending_commits", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual timeout required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wave_param_loader.md
Name: wave_param_loader

Overview:
- Upstream configuration stage for the 64-channel oscillator summing block.
- Accepts 16-bit parameter words (amplitude, offset, phase word) for any channel through a command/data handshake and stores them in shadow banks.
- Drives the three 1024-bit active buses the summing block consumes. A commit command copies all shadow banks to the active buses at once, so the oscillators never run on a half-updated parameter set.

Parameters:
- NCH, 64, number of oscillator channels (fixed at 64 for this revision).
- W, 16, width of each per-channel parameter word.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 burst write, 01 commit, 10 clear shadow, 11 reserved.
- cmd_sel  in  2  target bank: 00 amps, 01 offsets, 10 phasewords, 11 invalid.
- cmd_chan  in  6  burst start channel.
- cmd_len  in  6  burst length minus one (0 means 1 word, 63 means 64 words).
- data_valid  in  1  data word offered.
- data_ready  out  1  data word accepted when data_valid && data_ready.
- data  in  16  parameter word.
- amps  out  1024  active amplitudes; channel k occupies bits [16k+15:16k].
- offsets  out  1024  active offsets; same lane mapping.
- phasewords  out  1024  active phase words; same lane mapping.
- commit_done  out  1  one-cycle pulse after a commit.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous, active-high):
  - All shadow and active banks go to 0, so amps, offsets and phasewords are 0.
  - State goes to IDLE; commit_done = 0, err = 0, cmd_ready = 1, data_ready = 0.
- States: IDLE, BURST.
- cmd_ready = 1 only in IDLE. data_ready = 1 only in BURST.
- IDLE, burst accepted (op 00):
  - Latch sel, set chan_ptr = cmd_chan and remaining = cmd_len.
  - Go to BURST on the next edge.
- BURST, each accepted data word:
  - Write shadow[sel][chan_ptr] = data at that edge.
  - chan_ptr increments modulo 64 (63 wraps to 0).
  - If remaining == 0, return to IDLE on this edge; otherwise decrement remaining.
  - cmd_ready is therefore 1 in the cycle after the last word.
  - data_valid low in BURST stalls the burst with no timeout.
- Burst with sel = 11:
  - The burst runs normally (same word count and handshake), but all writes are discarded.
  - err is set at the acceptance edge.
- Commit (op 01), accepted in IDLE:
  - All three active buses load their full shadow banks at the acceptance edge.
  - commit_done = 1 for exactly the following cycle.
  - Stay in IDLE.
  - Back-to-back commits produce back-to-back pulses.
- Clear (op 10), accepted in IDLE:
  - All shadow banks go to 0 at the acceptance edge. Active buses are unchanged.
- Reserved op (op 11):
  - Accepted (handshake completes), err set, no other effect.
- Active buses change only on a commit or on reset. Shadow writes are never visible on the outputs before a commit.
- Reset asserted mid-burst: the partial burst is abandoned and all banks are zeroed. No commit is implied.
- Commands cannot be accepted during BURST, so there are no simultaneous command/data writes.
- err is cleared only by reset.
- Outputs are registered; there is no combinational path from data to amps, offsets or phasewords.

Test Plan:
- Reset, then idle 10 cycles:
  - amps = offsets = phasewords = 0, cmd_ready = 1, data_ready = 0, err = 0.
- Burst sel = 00, chan = 0, len = 63, every word 16'h1000, then commit:
  - Before commit, amps = 0.
  - The edge after commit acceptance, amps = {64{16'h1000}}.
  - commit_done high for one cycle.
- Burst sel = 10, chan = 62, len = 3, data 16'h0001, 0002, 0003, 0004, then commit:
  - Lanes 62, 63, 0, 1 = 1, 2, 3, 4 (wrap verified).
  - All other phaseword lanes unchanged.
- Burst with data_valid toggling every other cycle, len = 4:
  - Exactly 5 words written.
  - cmd_ready returns the cycle after the 5th acceptance.
- Clear, then commit, after loading offsets = 16'h00FF everywhere:
  - Offsets stay 16'h00FF after the clear.
  - Offsets become 0 after the commit.
- Burst sel = 11, len = 1, then op 11:
  - err = 1 and stays set.
  - No shadow lane changes; a subsequent commit leaves outputs equal to their prior values.
- Assert reset mid-burst after 2 of 8 words:
  - Outputs 0 immediately (asynchronous).
  - State IDLE, cmd_ready = 1.
